ccu_snoop_arbiter: RTL

- Shares the single snoop-crossbar port (AC request, CR response, CD data) between NumReq snoop controllers. Index 0 is the read-snoop FSM; index 1 is the write-snoop FSM.
- Arbitrates AC requests round-robin.
- Records grant order and steers each CR response and its optional CD burst back to the requester that issued the snoop, in AC order.
- Sits between the CCU snoop controllers and the snoop crossbar.

---
 rtl/ccu_snoop_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ccu_snoop_arbiter.sv
// CCU snoop port arbiter: shares one snoop-crossbar port (AC/CR/CD) between
// NumReq snoop controllers. AC requests are granted round-robin; the grant
// order is recorded so CR responses and CD bursts are routed back in AC order.
// Payload layout: cr_resp_t bit 0 is DataTransfer, cd_chan_t bit 0 is last.

// Small synchronous FIFO holding requester indices for the route stages.
module ccu_snoop_arbiter_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned DataW = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    input  logic             pop_i,
    output logic [DataW-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataW-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [CntW-1:0]  r_cnt;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count only, so a coincident pop
    // never lets a push into a full FIFO.
    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == CntW'(0));
    assign data_o  = r_mem[r_rd];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Storage, pointer and occupancy update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= data_i;
                r_wr        <= (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// Protocol checker: a CR beat must never arrive with no snoop outstanding.
module ccu_snoop_arbiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic snp_cr_valid_i,
    input logic cr_empty_i
);
    a_cr_without_ac: assert property (@(posedge clk_i) disable iff (!rst_ni)
        snp_cr_valid_i |-> !cr_empty_i);
endmodule

module ccu_snoop_arbiter #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned MaxTrans = 4,
    parameter type ac_chan_t = logic [47:0],
    parameter type cr_resp_t = logic [4:0],
    parameter type cd_chan_t = logic [64:0]
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_ac_valid_i,
    output logic [NumReq-1:0]       req_ac_ready_o,
    input  ac_chan_t [NumReq-1:0]   req_ac_i,
    output logic [NumReq-1:0]       req_cr_valid_o,
    input  logic [NumReq-1:0]       req_cr_ready_i,
    output cr_resp_t [NumReq-1:0]   req_cr_resp_o,
    output logic [NumReq-1:0]       req_cd_valid_o,
    input  logic [NumReq-1:0]       req_cd_ready_i,
    output cd_chan_t [NumReq-1:0]   req_cd_o,
    output logic                    snp_ac_valid_o,
    input  logic                    snp_ac_ready_i,
    output ac_chan_t                snp_ac_o,
    input  logic                    snp_cr_valid_i,
    output logic                    snp_cr_ready_o,
    input  cr_resp_t                snp_cr_resp_i,
    input  logic                    snp_cd_valid_i,
    output logic                    snp_cd_ready_o,
    input  cd_chan_t                snp_cd_i
);
    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] r_rr;
    logic            r_lock;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] w_rr_idx;
    logic [IdxW-1:0] w_grant;
    logic            w_ac_hs;
    logic            w_cr_full, w_cr_empty, w_cr_ok, w_cr_hs, w_cr_dt;
    logic [IdxW-1:0] w_cr_head;
    logic            w_cd_full, w_cd_empty, w_cd_pop;
    logic [IdxW-1:0] w_cd_head;

    // Round-robin search for the first valid requester at or after r_rr.
    always_comb begin
        int  k;
        logic found;
        k        = 0;
        found    = 1'b0;
        w_rr_idx = r_rr;
        for (int i = 0; i < int'(NumReq); i++) begin
            k = int'(r_rr) + i;
            if (k >= int'(NumReq)) begin
                k = k - int'(NumReq);
            end else begin
                k = k;
            end
            if (!found && req_ac_valid_i[k]) begin
                found    = 1'b1;
                w_rr_idx = IdxW'(k);
            end else begin
                found    = found;
            end
        end
    end

    // A stalled grant stays locked so the crossbar sees a stable AC payload.
    assign w_grant = r_lock ? r_lock_idx : w_rr_idx;

    // AC mux towards the crossbar; ready only returns to the granted index.
    always_comb begin
        snp_ac_valid_o          = (|req_ac_valid_i) && !w_cr_full;
        snp_ac_o                = req_ac_i[w_grant];
        req_ac_ready_o          = '0;
        req_ac_ready_o[w_grant] = snp_ac_ready_i && !w_cr_full;
    end

    assign w_ac_hs = snp_ac_valid_o && snp_ac_ready_i;

    // Round-robin pointer advance and stall lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_ac_hs) begin
            r_rr   <= (w_grant == IdxW'(NumReq - 1)) ? '0 : w_grant + IdxW'(1);
            r_lock <= 1'b0;
        end else if (snp_ac_valid_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end else begin
            r_lock <= 1'b0;
        end
    end

    // A data-carrying CR may only pass when its CD route can be recorded.
    assign w_cr_dt = snp_cr_resp_i[0];
    assign w_cr_ok = !w_cr_empty && (!w_cd_full || !w_cr_dt);
    assign w_cr_hs = snp_cr_valid_i && snp_cr_ready_o;

    // CR steering to the head-of-line requester; payload is broadcast.
    always_comb begin
        req_cr_valid_o            = '0;
        req_cr_valid_o[w_cr_head] = snp_cr_valid_i && w_cr_ok;
        snp_cr_ready_o            = w_cr_ok && req_cr_ready_i[w_cr_head];
        for (int i = 0; i < int'(NumReq); i++) begin
            req_cr_resp_o[i] = snp_cr_resp_i;
        end
    end

    // CD steering; the route is retired on the beat flagged last.
    always_comb begin
        req_cd_valid_o            = '0;
        req_cd_valid_o[w_cd_head] = snp_cd_valid_i && !w_cd_empty;
        snp_cd_ready_o            = req_cd_ready_i[w_cd_head] && !w_cd_empty;
        for (int i = 0; i < int'(NumReq); i++) begin
            req_cd_o[i] = snp_cd_i;
        end
    end

    assign w_cd_pop = snp_cd_valid_i && snp_cd_ready_o && snp_cd_i[0];

    ccu_snoop_arbiter_fifo #(.Depth(MaxTrans), .DataW(IdxW)) u_cr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_ac_hs),
        .data_i  (w_grant),
        .pop_i   (w_cr_hs),
        .data_o  (w_cr_head),
        .empty_o (w_cr_empty),
        .full_o  (w_cr_full)
    );

    ccu_snoop_arbiter_fifo #(.Depth(MaxTrans), .DataW(IdxW)) u_cd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_cr_hs && w_cr_dt),
        .data_i  (w_cr_head),
        .pop_i   (w_cd_pop),
        .data_o  (w_cd_head),
        .empty_o (w_cd_empty),
        .full_o  (w_cd_full)
    );

    ccu_snoop_arbiter_chk u_chk (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .snp_cr_valid_i (snp_cr_valid_i),
        .cr_empty_i     (w_cr_empty)
    );
endmodule
